// File: rtl/word_scroll_driver_if.sv
// Control and display bundle for word_scroll_driver.
// The master side drives the controls; the slave side (the driver) returns codes and segments.
interface word_scroll_driver_if;
  logic       i_enable;
  logic       i_dir;
  logic       i_load;
  logic [5:0] i_char_in;
  logic [1:0] o_phase;
  logic       o_step;
  logic [1:0] o_code2;
  logic [1:0] o_code1;
  logic [1:0] o_code0;
  logic [6:0] o_hex2;
  logic [6:0] o_hex1;
  logic [6:0] o_hex0;

  modport master (
    output i_enable, i_dir, i_load, i_char_in,
    input  o_phase, o_step, o_code2, o_code1, o_code0, o_hex2, o_hex1, o_hex0
  );

  modport slave (
    input  i_enable, i_dir, i_load, i_char_in,
    output o_phase, o_step, o_code2, o_code1, o_code0, o_hex2, o_hex1, o_hex0
  );
endinterface

// File: rtl/word_scroll_driver.sv
// Rotates a loaded 3-character word across HEX2..HEX0, one position every TICKS enabled cycles.
// Outputs rotated 2-bit codes and active-low 7-segment patterns.
module word_scroll_driver #(
  parameter int unsigned TICKS = 50000000
) (
  input logic           i_clk,
  input logic           i_rst,
  word_scroll_driver_if.slave bus
);
  localparam int unsigned W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  phase_t       r_phase, w_phase_next;
  logic [W-1:0] r_count, w_count_next;
  logic [5:0]   r_word, w_word_next;
  logic         r_step, w_step_next;
  logic         w_tick;
  logic [1:0]   w_c2, w_c1, w_c0;

  assign w_tick = bus.i_enable && !bus.i_load && (r_count == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word  <= '1;
      r_phase <= PH0;
      r_count <= '0;
      r_step  <= 1'b0;
    end else begin
      r_word  <= w_word_next;
      r_phase <= w_phase_next;
      r_count <= w_count_next;
      r_step  <= w_step_next;
    end
  end

  // Load wins over a coincident tick; an out-of-range phase falls back to 0 on the next tick.
  always_comb begin
    w_word_next  = r_word;
    w_phase_next = r_phase;
    w_count_next = r_count;
    w_step_next  = 1'b0;
    if (bus.i_load) begin
      w_word_next  = bus.i_char_in;
      w_phase_next = PH0;
      w_count_next = '0;
    end else if (bus.i_enable) begin
      if (w_tick) begin
        w_count_next = '0;
        w_step_next  = 1'b1;
        case (r_phase)
          PH0:     w_phase_next = bus.i_dir ? PH2 : PH1;
          PH1:     w_phase_next = bus.i_dir ? PH0 : PH2;
          PH2:     w_phase_next = bus.i_dir ? PH1 : PH0;
          default: w_phase_next = PH0;
        endcase
      end else begin
        w_count_next = r_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_c2 = r_word[5:4];
    w_c1 = r_word[3:2];
    w_c0 = r_word[1:0];
    case (r_phase)
      PH1:     {w_c2, w_c1, w_c0} = {r_word[3:2], r_word[1:0], r_word[5:4]};
      PH2:     {w_c2, w_c1, w_c0} = {r_word[1:0], r_word[5:4], r_word[3:2]};
      default: {w_c2, w_c1, w_c0} = r_word;
    endcase
  end

  function automatic logic [6:0] seg(input logic [1:0] c);
    case (c)
      2'b00:   return 7'b0100100;
      2'b01:   return 7'b0010010;
      2'b10:   return 7'b0110000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign bus.o_phase = r_phase;
  assign bus.o_step  = r_step;
  assign bus.o_code2 = w_c2;
  assign bus.o_code1 = w_c1;
  assign bus.o_code0 = w_c0;
  assign bus.o_hex2  = seg(w_c2);
  assign bus.o_hex1  = seg(w_c1);
  assign bus.o_hex0  = seg(w_c0);
endmodule
